// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I fetch/execute datapath: latches the IR,
// sequences PC/regfile/ALU/data-memory strobes, counts retirements and traps.
module multicycle_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic [31:0]      ir,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam int         TW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timeout_q;
  logic          ir_load;
  logic          rw_raw;
  logic [6:0]    opcode;
  logic          legal;

  assign opcode = ir[6:0];
  assign legal  = (opcode == OP_IMM)  || (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                  (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);

  always_comb begin
    state_d     = state_q;
    ir_load     = 1'b0;
    rw_raw      = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    wb_sel      = 2'b00;
    alu_src_imm = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_load = run;
        state_d = run ? S_DECODE : S_IDLE;
      end
      S_DECODE: begin
        if (ir == 32'h0) begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = legal ? S_EXEC : S_TRAP;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_IMM: begin
            alu_src_imm = 1'b1;
            state_d     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_imm = 1'b1;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
            state_d  = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            rw_raw   = 1'b1;
            wb_sel   = 2'b10;
            pc_write = 1'b1;
            pc_src   = (opcode == OP_JAL) ? 2'b01 : 2'b10;
            state_d  = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req     = 1'b1;
        mem_we      = (opcode == OP_STORE);
        alu_src_imm = 1'b1;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_q == TO_LAST) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        rw_raw   = 1'b1;
        wb_sel   = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // x0 is hardwired, so never strobe a write to it
  assign reg_write = rw_raw & (|ir[11:7]);
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir          <= 32'h0;
      trap        <= 1'b0;
      instr_count <= '0;
      timeout_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir <= instr;
      if (state_d == S_TRAP) trap <= 1'b1;
      // counter only advances while we remain in MEM, so it clears on any exit
      if (state_q == S_MEM && state_d == S_MEM) timeout_q <= timeout_q + 1'b1;
      else                                      timeout_q <= '0;
      if (pc_write && state_q != S_DECODE && instr_count != '1)
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle sequences built from the
// ISA-level rules, replayed cycle by cycle with random noise on don't-care inputs.
module tb_multicycle_ctrl;

  localparam int CW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst, run, branch_taken, mem_ready;
  logic [31:0]   instr, ir;
  logic          pc_write, reg_write, alu_src_imm, mem_req, mem_we, trap;
  logic [1:0]    pc_src, wb_sel;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .ir(ir), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
    .mem_req(mem_req), .mem_we(mem_we), .state(state), .trap(trap),
    .instr_count(instr_count)
  );

  typedef struct packed {
    logic        run;
    logic [31:0] instr;
    logic        bt;
    logic        rdy;
    logic [2:0]  st;
    logic [31:0] ir;
    logic        pcw;
    logic [1:0]  src;
    logic        rw;
    logic [1:0]  wb;
    logic        alu;
    logic        mreq;
    logic        mwe;
    logic        trap;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] m_ir;
  int          m_cnt;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one cycle with inputs the design should ignore randomised
  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t r;
    r       = '0;
    r.run   = 1'b1;
    r.instr = $urandom;
    r.bt    = 1'($urandom);
    r.rdy   = 1'($urandom);
    r.st    = st;
    r.ir    = m_ir;
    return r;
  endfunction

  // expected cycles for one instruction; wait_n = MEM cycle on which ready arrives (0 = never)
  task automatic add_instr(input logic [31:0] ins, input logic bt, input int wait_n);
    cyc_t r;
    logic [6:0] op;
    logic rd;
    op = ins[6:0];
    rd = (ins[11:7] != 5'd0);
    r = mk(3'd1); r.instr = ins; q.push_back(r);
    m_ir = ins;
    r = mk(3'd2);
    if (ins == 32'h0) begin
      r.pcw = 1'b1; q.push_back(r); return;
    end
    q.push_back(r);
    if (!(op inside {7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67})) begin
      r = mk(3'd6); r.trap = 1'b1; q.push_back(r); return;
    end
    r = mk(3'd3);
    case (op)
      7'h13: begin
        r.alu = 1'b1; q.push_back(r);
        r = mk(3'd5); r.rw = rd; r.pcw = 1'b1; q.push_back(r);
      end
      7'h63: begin
        r.bt = bt; r.pcw = 1'b1; r.src = bt ? 2'b01 : 2'b00; q.push_back(r);
      end
      7'h6F, 7'h67: begin
        r.rw = rd; r.wb = 2'b10; r.pcw = 1'b1;
        r.src = (op == 7'h6F) ? 2'b01 : 2'b10; q.push_back(r);
      end
      default: begin
        r.alu = 1'b1; q.push_back(r);
        for (int k = 1; k <= TO; k++) begin
          r = mk(3'd4); r.mreq = 1'b1; r.mwe = (op == 7'h23); r.alu = 1'b1;
          r.rdy = (k == wait_n);
          if (k == wait_n) begin
            if (op == 7'h23) begin
              r.pcw = 1'b1; q.push_back(r);
            end else begin
              q.push_back(r);
              r = mk(3'd5); r.rw = rd; r.wb = 2'b01; r.pcw = 1'b1; q.push_back(r);
            end
            return;
          end
          q.push_back(r);
        end
        r = mk(3'd6); r.trap = 1'b1; q.push_back(r);
      end
    endcase
  endtask

  task automatic step(input cyc_t r);
    @(negedge clk);
    rst = 1'b0; run = r.run; instr = r.instr; branch_taken = r.bt; mem_ready = r.rdy;
    #1;
    chk("state", 32'(state), 32'(r.st));
    chk("ir", ir, r.ir);
    chk("pc_write", 32'(pc_write), 32'(r.pcw));
    chk("pc_src", 32'(pc_src), 32'(r.src));
    chk("reg_write", 32'(reg_write), 32'(r.rw));
    chk("wb_sel", 32'(wb_sel), 32'(r.wb));
    chk("alu_src_imm", 32'(alu_src_imm), 32'(r.alu));
    chk("mem_req", 32'(mem_req), 32'(r.mreq));
    chk("mem_we", 32'(mem_we), 32'(r.mwe));
    chk("trap", 32'(trap), 32'(r.trap));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
    if (r.pcw && r.st != 3'd2 && m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic drain();
    while (q.size() > 0) step(q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'($urandom); instr = $urandom; mem_ready = 1'($urandom);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_strobes", {24'd0, pc_write, reg_write, alu_src_imm, mem_req, mem_we, pc_src == 2'b00, 2'b00},
        32'h4);
    m_ir = 32'h0; m_cnt = 0;
    q.push_back(mk(3'd0));
  endtask

  task automatic rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [6];
    cyc_t r;
    ops = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    ins = {$urandom} ;
    ins[6:0] = ops[$urandom_range(5)];
    if ($urandom_range(3) == 0) ins[11:7] = 5'd0;
    if ($urandom_range(9) == 0) ins = 32'h0;
    // occasionally drop run at FETCH and idle a little before resuming
    if ($urandom_range(5) == 0) begin
      r = mk(3'd1); r.run = 1'b0; q.push_back(r);
      for (int g = $urandom_range(2); g > 0; g--) begin
        r = mk(3'd0); r.run = 1'b0; q.push_back(r);
      end
      q.push_back(mk(3'd0));
    end
    add_instr(ins, 1'($urandom), $urandom_range(1, 4));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instr = 32'h0; branch_taken = 1'b0; mem_ready = 1'b0;
    m_ir = 32'h0; m_cnt = 0;
    do_reset();

    add_instr(32'h00450693, 1'b0, 0);
    add_instr(32'h0006a803, 1'b0, 3);
    add_instr(32'h00b76463, 1'b1, 0);
    add_instr(32'h00b76463, 1'b0, 0);
    add_instr(32'h00008067, 1'b0, 0);
    add_instr(32'hfc1ff06f, 1'b0, 0);
    add_instr(32'h00000000, 1'b0, 0);
    add_instr(32'h01162023, 1'b0, 1);
    drain();

    for (int i = 0; i < 60; i++) begin
      rand_instr();
      drain();
    end

    add_instr(32'h0000007f, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc_t r;
      r = mk(3'd6); r.run = 1'($urandom); r.trap = 1'b1; q.push_back(r);
    end
    drain();
    do_reset();

    add_instr(32'h01162023, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_t r;
      r = mk(3'd6); r.trap = 1'b1; q.push_back(r);
    end
    drain();
    do_reset();

    for (int i = 0; i < 25; i++) begin
      rand_instr();
      drain();
    end

    // reset while a store is waiting on memory
    add_instr(32'h01162023, 1'b0, 0);
    for (int i = 0; i < 6; i++) step(q.pop_front());
    q.delete();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    chk("mid_mem_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    #1;
    chk("mid_mem_state", 32'(state), 32'd0);
    chk("mid_mem_req", 32'(mem_req), 32'd0);
    chk("mid_mem_count", 32'(instr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
